// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port ids, FSM state type and default lock budget.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef logic [1:0] arb_id_t;

  localparam arb_id_t ARB_ID_NONE = 2'd0;
  localparam arb_id_t ARB_ID_C    = 2'd1;
  localparam arb_id_t ARB_ID_L    = 2'd2;

  localparam int ARB_MAX_LOCK   = 16;
  localparam int ARB_LOCK_CNT_W = 5;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the memory arbiter.
// In: c_req, l_req, l_lock, state, lock_cnt, rr_last
//     (rr_last only with ARB_ROUND_ROBIN_EN). Out: gnt_id.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK   = ARB_MAX_LOCK,
  parameter int LOCK_CNT_W = ARB_LOCK_CNT_W
) (
  input  logic                  c_req,
  input  logic                  l_req,
  input  logic                  l_lock,
  input  arb_state_t            state,
  input  logic [LOCK_CNT_W-1:0] lock_cnt,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_id_t               rr_last,
`endif
  output arb_id_t               gnt_id
);

  localparam logic [LOCK_CNT_W-1:0] MAX_V =
    LOCK_CNT_W'(MAX_LOCK);

  arb_id_t tie_id;
  arb_id_t idle_id;
  logic    locked;
  logic    force_c;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_id = (rr_last == ARB_ID_C) ?
             ARB_ID_L : ARB_ID_C;
`else
    tie_id = ARB_ID_C;
`endif
    idle_id = ARB_ID_NONE;
    unique case (1'b1)
      c_req  &&  l_req: idle_id = tie_id;
      c_req  && !l_req: idle_id = ARB_ID_C;
      !c_req &&  l_req: idle_id = ARB_ID_L;
      default:          idle_id = ARB_ID_NONE;
    endcase
  end

  // A dropped l_lock falls back to idle rules in
  // the same cycle, so a waiting core wins at once.
  assign locked  = (state == ARB_LOCKED) && l_lock;
  assign force_c = c_req && (lock_cnt >= MAX_V);

  always_comb begin
    gnt_id = idle_id;
    if (locked) begin
      unique case (1'b1)
        force_c:           gnt_id = ARB_ID_C;
        !force_c && l_req: gnt_id = ARB_ID_L;
        default:           gnt_id = ARB_ID_NONE;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter (core C, loader L) onto one 1-cycle-latency data memory.
// Ports: c_*/l_* request+return, l_lock, mem_* to memory; macro ARB_ROUND_ROBIN_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_LOCK   = ARB_MAX_LOCK,
  parameter int LOCK_CNT_W = ARB_LOCK_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [2:0]        c_fn3,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic [2:0]        l_fn3,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_fn3,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t            state, state_d;
  logic [LOCK_CNT_W-1:0] lock_cnt, cnt_d;
  arb_id_t               rd_owner, owner_d;
  arb_id_t               pick_id;
  logic                  xfer;
  logic                  xfer_we;

`ifdef ARB_ROUND_ROBIN_EN
  arb_id_t rr_last;
`endif

  mem_arb_pick #(
    .MAX_LOCK   (MAX_LOCK),
    .LOCK_CNT_W (LOCK_CNT_W)
  ) u_pick (
    .c_req    (c_req),
    .l_req    (l_req),
    .l_lock   (l_lock),
    .state    (state),
    .lock_cnt (lock_cnt),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_last  (rr_last),
`endif
    .gnt_id   (pick_id)
  );

  // Reset masks every grant so nothing reaches memory.
  assign c_gnt   = !rst && (pick_id == ARB_ID_C);
  assign l_gnt   = !rst && (pick_id == ARB_ID_L);
  assign c_stall = c_req && !c_gnt;
  assign xfer    = c_gnt || l_gnt;

  // Core fields are the resting value of the mux.
  assign mem_addr  = l_gnt ? l_addr  : c_addr;
  assign mem_wdata = l_gnt ? l_wdata : c_wdata;
  assign mem_fn3   = l_gnt ? l_fn3   : c_fn3;
  assign xfer_we   = l_gnt ? l_we    : c_we;
  assign mem_wen   = xfer && xfer_we;

  // rvalid is masked during reset so a read issued
  // just before reset never returns.
  assign c_rvalid = !rst && (rd_owner == ARB_ID_C);
  assign l_rvalid = !rst && (rd_owner == ARB_ID_L);
  assign c_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

  always_comb begin
    owner_d = ARB_ID_NONE;
    if (xfer && !xfer_we)
      owner_d = c_gnt ? ARB_ID_C : ARB_ID_L;
  end

  always_comb begin
    state_d = state;
    cnt_d   = lock_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (l_gnt && l_lock) begin
          state_d = ARB_LOCKED;
          cnt_d   = LOCK_CNT_W'(1);
        end
      end
      ARB_LOCKED: begin
        unique case (1'b1)
          !l_lock: begin
            state_d = ARB_IDLE;
            cnt_d   = '0;
          end
          l_lock && c_gnt: cnt_d = '0;
          l_lock && l_gnt: begin
            if (lock_cnt != '1)
              cnt_d = lock_cnt + 1'b1;
          end
          default: cnt_d = lock_cnt;
        endcase
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lock_cnt <= '0;
      rd_owner <= ARB_ID_NONE;
    end else begin
      state    <= state_d;
      lock_cnt <= cnt_d;
      rd_owner <= owner_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)
      rr_last <= ARB_ID_C;
    else if (xfer)
      rr_last <= c_gnt ? ARB_ID_C : ARB_ID_L;
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MAX_LOCK=4).
// Behavioural 1-cycle memory; expectations are hand-computed.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_fn3;
  logic        c_gnt, c_rvalid, c_stall;
  logic [31:0] c_rdata;
  logic        l_req, l_we, l_lock;
  logic [31:0] l_addr, l_wdata;
  logic [2:0]  l_fn3;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_fn3;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  logic [9:0] burst_c;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_LOCK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .c_req     (c_req),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_fn3     (c_fn3),
    .c_gnt     (c_gnt),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .c_stall   (c_stall),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_fn3     (l_fn3),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_fn3   (mem_fn3),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      mem[4] <= 32'h1111_0010;
      mem[8] <= 32'h2222_0020;
    end else if (mem_wen) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0b want %0b",
             tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h",
             tag, obs, exp);
    end
  endtask

  task automatic quiet();
    c_req = 0; c_we = 0; c_addr = 0;
    c_wdata = 0; c_fn3 = 3'b010;
    l_req = 0; l_we = 0; l_addr = 0;
    l_wdata = 0; l_fn3 = 3'b010; l_lock = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    quiet();
    rst = 1;
    c_req = 1; c_we = 1;
    step(); #1;
    chk1("rst_cgnt", c_gnt, 0);
    chk1("rst_lgnt", l_gnt, 0);
    chk1("rst_wen", mem_wen, 0);
    chk1("rst_stall", c_stall, 1);
    chk1("rst_crv", c_rvalid, 0);
    chk1("rst_lrv", l_rvalid, 0);

    // core write then read
    step();
    rst = 0;
    c_req = 1; c_we = 1;
    c_addr = 32'h40; c_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("st_idle0", dut.state == ARB_IDLE, 1);
    chk1("cnt0", dut.lock_cnt == '0, 1);
    chk1("w_cgnt", c_gnt, 1);
    chk1("w_wen", mem_wen, 1);
    chk32("w_addr", mem_addr, 32'h40);
    chk32("w_data", mem_wdata, 32'hDEAD_BEEF);
    chk1("w_lgnt", l_gnt, 0);
    step();
    c_we = 0;
    #1;
    chk1("r_cgnt", c_gnt, 1);
    chk1("r_wen", mem_wen, 0);
    chk1("w_norv", c_rvalid, 0);
    step();
    quiet();
    #1;
    chk1("r_crv", c_rvalid, 1);
    chk32("r_cdat", c_rdata, 32'hDEAD_BEEF);
    chk1("r_lrv", l_rvalid, 0);

    // simultaneous idle reads
    step();
    c_req = 1; c_addr = 32'h10;
    l_req = 1; l_addr = 32'h20;
    #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk1("tie_lgnt", l_gnt, 1);
    chk1("tie_cgnt", c_gnt, 0);
    chk1("tie_stall", c_stall, 1);
    chk32("tie_addr", mem_addr, 32'h20);
    step();
    l_req = 0;
    #1;
    chk1("tie2_cgnt", c_gnt, 1);
    chk1("tie2_lrv", l_rvalid, 1);
    chk32("tie2_ldat", l_rdata, 32'h2222_0020);
    step();
    quiet();
    #1;
    chk1("tie3_crv", c_rvalid, 1);
    chk32("tie3_cdat", c_rdata, 32'h1111_0010);
    chk1("tie3_lrv", l_rvalid, 0);
`else
    chk1("tie_cgnt", c_gnt, 1);
    chk1("tie_lgnt", l_gnt, 0);
    chk1("tie_stall", c_stall, 0);
    chk32("tie_addr", mem_addr, 32'h10);
    step();
    c_req = 0;
    #1;
    chk1("tie2_lgnt", l_gnt, 1);
    chk32("tie2_addr", mem_addr, 32'h20);
    chk1("tie2_crv", c_rvalid, 1);
    chk32("tie2_cdat", c_rdata, 32'h1111_0010);
    step();
    quiet();
    #1;
    chk1("tie3_lrv", l_rvalid, 1);
    chk32("tie3_ldat", l_rdata, 32'h2222_0020);
    chk1("tie3_crv", c_rvalid, 0);
`endif

    // locked burst, MAX_LOCK=4
    step();
    l_req = 1; l_lock = 1; l_we = 1;
    l_addr = 32'h80; l_wdata = 32'h5A5A_0080;
    #1;
    chk1("lk_enter", l_gnt, 1);
    burst_c = 10'b01_0000_1000;
    for (int k = 0; k < 10; k++) begin
      step();
      c_req = 1; c_we = 1;
      c_addr = 32'h84; c_wdata = 32'h0C0C_0084;
      #1;
      chk1($sformatf("lk%0d_c", k), c_gnt, burst_c[k]);
      chk1($sformatf("lk%0d_l", k), l_gnt, !burst_c[k]);
      chk1($sformatf("lk%0d_s", k), c_stall, !burst_c[k]);
    end

    // lock release with core waiting
    step();
    l_lock = 0;
    #1;
    chk1("rel_cgnt", c_gnt, 1);
    chk1("rel_lgnt", l_gnt, 0);
    step();
    quiet();
    #1;
    chk1("rel_idle", dut.state == ARB_IDLE, 1);
    chk1("rel_cnt", dut.lock_cnt == '0, 1);

    // reset during a loader read
    step();
    l_req = 1; l_lock = 1; l_addr = 32'h20;
    #1;
    chk1("rr_lgnt", l_gnt, 1);
    step();
    rst = 1; c_req = 1; c_we = 1;
    #1;
    chk1("rr_lrv", l_rvalid, 0);
    chk1("rr_lgnt0", l_gnt, 0);
    chk1("rr_cgnt0", c_gnt, 0);
    chk1("rr_wen0", mem_wen, 0);
    chk1("rr_stall", c_stall, 1);
    step();
    rst = 0;
    quiet();
    #1;
    chk1("rr_idle", dut.state == ARB_IDLE, 1);
    chk1("rr_cnt", dut.lock_cnt == '0, 1);
    chk1("rr_lrv2", l_rvalid, 0);
    chk1("rr_crv2", c_rvalid, 0);

    // interleaved reads
    step();
    c_req = 1; c_addr = 32'h10;
    #1;
    chk1("il_cgnt", c_gnt, 1);
    step();
    c_req = 0;
    l_req = 1; l_addr = 32'h20;
    #1;
    chk1("il_lgnt", l_gnt, 1);
    chk1("il_crv", c_rvalid, 1);
    chk32("il_cdat", c_rdata, 32'h1111_0010);
    chk1("il_lrv0", l_rvalid, 0);
    step();
    quiet();
    #1;
    chk1("il_lrv", l_rvalid, 1);
    chk32("il_ldat", l_rdata, 32'h2222_0020);
    chk1("il_crv0", c_rvalid, 0);

    // burst writes landed in memory
    chk32("mem80", mem[32], 32'h5A5A_0080);
    chk32("mem84", mem[33], 32'h0C0C_0084);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single synchronous data-memory port (DataMem-style, 1-cycle read latency, fn3-sized access) between two requesters: the core's MEM stage (port C) and the UART boot/debug loader (port L).
- Sits between the MMU SRAM path and DataMem.
- Produces a stall to the HazardUnit when the core loses arbitration.
- Supports a loader lock for burst programming, with a starvation limit so the core still makes progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_LOCK, 16, loader transfers allowed while locked before one core transfer is forced if the core is waiting.
- LOCK_CNT_W, 5, lock counter width; must hold MAX_LOCK.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_fn3  in  3  core access size/sign (RISC-V funct3)
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- c_stall  out  1  c_req & ~c_gnt, to HazardUnit
- l_req, l_we, l_addr, l_wdata, l_fn3  in  1/1/ADDR_W/DATA_W/3  loader request fields, same meaning as core fields
- l_lock  in  1  loader requests bus ownership across transfers
- l_gnt  out  1  loader request accepted
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_fn3  out  3  to memory
- mem_wen  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, lock_cnt=0, rr_last=C, rd_owner=none.
  - c_rvalid=l_rvalid=0.
  - While rst=1: c_gnt=l_gnt=0, mem_wen=0, c_stall=c_req.
  - An in-flight read is discarded; no rvalid is issued after reset.
- Transfer rules:
  - Transfer happens when req & gnt in the same cycle. Grant is combinational from the current state and requests.
  - At most one grant per cycle.
  - Mux outputs drive the selected requester's fields. With no grant: mem_wen=0 and mem_* hold the core's fields.
  - mem_wen = granted & we.
- Read latency:
  - A granted read sets rd_owner for one cycle.
  - The next cycle drives x_rvalid=1 with x_rdata=mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads from different owners are allowed; each rvalid goes only to its own requester.
- FSM states IDLE, LOCKED:
  - IDLE: if both request, pick by priority (fixed: C first). A single requester wins. Granting L with l_lock=1 goes to LOCKED with lock_cnt=1.
  - LOCKED:
    - If l_lock=0, return to IDLE. This cycle arbitrates as IDLE.
    - Otherwise, if c_req=1 and lock_cnt>=MAX_LOCK, grant C and clear lock_cnt to 0; stay LOCKED.
    - Otherwise grant L if l_req, and lock_cnt saturating-increments on each L transfer.
    - C is never granted in LOCKED except through the forced slot.
  - Idle cycles in LOCKED (l_req=0, l_lock=1) do not advance lock_cnt and do not grant C unless lock_cnt>=MAX_LOCK.
- Boundaries:
  - MAX_LOCK=0 means every waiting core request is forced immediately.
  - lock_cnt saturates at its maximum and never wraps.
  - Simultaneous l_lock fall and c_req: core is granted in that cycle (IDLE rules).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: IDLE ties are resolved round-robin. rr_last records the last granted port, and the other port wins a tie. rr_last updates on every transfer and resets to C, so the first tie goes to L.
- Undefined: fixed priority, core always wins IDLE ties; rr_last is not implemented.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_LOCKED};
  - port-id constants ARB_ID_NONE, ARB_ID_C, ARB_ID_L;
  - default MAX_LOCK.
- One sub-module, mem_arb_pick. It is combinational: it takes both requests, state, lock_cnt and rr_last and returns the grant id.
- The FSM, counters and the read-return register stay in mem_bus_arbiter.

Test Plan:
- Core-only: core write 0xDEADBEEF to 0x40, then read 0x40. Expect c_gnt=1 both cycles, mem_wen=1 in cycle 0 only, c_rvalid=1 one cycle after the read grant with c_rdata=0xDEADBEEF, and l_rvalid=0.
- Simultaneous IDLE reads, C@0x10 and L@0x20, macro off: expect c_gnt first and c_stall=0, l_gnt next cycle. With ARB_ROUND_ROBIN_EN after reset: l_gnt first and c_stall=1 for one cycle.
- Locked burst with MAX_LOCK=4, l_lock=1, l_req continuous, c_req=1 from cycle 0: expect 4 L grants, then 1 C grant, then L resumes; the pattern repeats; c_stall is high exactly in non-granted cycles.
- Lock release: l_lock drops while c_req=1. Expect c_gnt in that same cycle and state=IDLE the next cycle.
- Reset mid-read: L read granted, rst=1 the next cycle. Expect l_rvalid=0, no grants while rst=1, and state=IDLE with lock_cnt=0 afterwards.
- Interleaved reads: C read then L read on consecutive cycles. Expect c_rvalid on cycle+1 and l_rvalid on cycle+2, each carrying its own address's data.
